// File: rtl/fifo_collector.sv
// Round-robin serial reader for the per-block result FIFOs: finds a non-empty
// block, shifts one word out of it MSB first and offers it on a valid/ready stream.
module fifo_collector #(
  parameter int BLOCKS    = 192,
  parameter int ID_WIDTH  = 8,
  parameter int WORD_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BLOCKS-1:0]    fifo_empty,
  input  logic [BLOCKS-1:0]    fifo_oflow,
  output logic [BLOCKS-1:0]    fifo_req,
  input  logic [BLOCKS-1:0]    fifo_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic [ID_WIDTH-1:0]  out_block,
  output logic [BLOCKS-1:0]    oflow_sticky,
  output logic                 oflow_any,
  input  logic                 oflow_clear
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);

  typedef enum logic [2:0] {S_SCAN, S_REQ, S_LAST, S_HOLD, S_SETTLE} state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-2:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] data_q, data_d, shifted;
  logic [ID_WIDTH-1:0]  block_q, block_d;
  logic                 valid_q, valid_d;
  logic [BLOCKS-1:0]    sel, sticky_q, sticky_d;
  logic                 any_q, bit_in, hit;

  // One-hot of the scan pointer; doubles as the request vector and the data mux.
  assign sel     = BLOCKS'(1) << ptr_q;
  assign bit_in  = |(fifo_bits & sel);
  assign hit     = |(~fifo_empty & sel);
  assign ptr_inc = (ptr_q == ID_WIDTH'(BLOCKS - 1)) ? '0 : ptr_q + 1'b1;
  assign shifted = {shift_q, bit_in};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    block_d = block_q;
    valid_d = valid_q;
    case (state_q)
      S_SCAN: begin
        if (enable && hit) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end else begin
          ptr_d = ptr_inc;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // First request cycle has no bit on the wire yet.
        if (cnt_q != '0) shift_d = shifted[WORD_BITS-2:0];
        if (cnt_q == CNT_W'(WORD_BITS - 1)) state_d = S_LAST;
      end
      S_LAST: begin
        data_d  = shifted;
        block_d = ptr_q;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_inc;
          state_d = S_SETTLE;
        end
      end
      // Gives the drained block a cycle to update its empty flag.
      S_SETTLE: state_d = S_SCAN;
      default:  state_d = S_SCAN;
    endcase
  end

  assign sticky_d = fifo_oflow | (sticky_q & ~{BLOCKS{oflow_clear}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SCAN;
      ptr_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      block_q  <= '0;
      valid_q  <= 1'b0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      block_q  <= block_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      any_q    <= |sticky_q;
    end
  end

  assign fifo_req     = (state_q == S_REQ) ? sel : '0;
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_block    = block_q;
  assign oflow_sticky = sticky_q;
  assign oflow_any    = any_q;

endmodule

// File: tb/tb_fifo_collector.sv
// Bench for fifo_collector: behavioural block FIFOs feed the serial link and a
// round-robin scoreboard predicts which word appears next.
module tb_fifo_collector;
  localparam int B  = 192;
  localparam int IW = 8;
  localparam int W  = 64;

  logic          clk, rst_n, enable, out_ready, oflow_clear;
  logic [B-1:0]  fifo_empty, fifo_oflow, fifo_req, fifo_bits, oflow_sticky;
  logic          out_valid, oflow_any;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_block;

  // Single-block build for the stale-empty case.
  logic [0:0] empty1, oflow1, req1, bits1, sticky1, blk1;
  logic       valid1, ready1, any1;
  logic [7:0] data1;

  int n_chk = 0, n_pass = 0;

  fifo_collector #(.BLOCKS(B), .ID_WIDTH(IW), .WORD_BITS(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_oflow(fifo_oflow), .fifo_req(fifo_req), .fifo_bits(fifo_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_block(out_block), .oflow_sticky(oflow_sticky), .oflow_any(oflow_any),
    .oflow_clear(oflow_clear));

  fifo_collector #(.BLOCKS(1), .ID_WIDTH(1), .WORD_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(empty1),
    .fifo_oflow(oflow1), .fifo_req(req1), .fifo_bits(bits1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1),
    .out_block(blk1), .oflow_sticky(sticky1), .oflow_any(any1),
    .oflow_clear(oflow_clear));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block FIFO models: words pushed by the stimulus, popped after the last request.
  logic [W-1:0] wmem [B][4];
  int pushed [B];
  int popped [B];
  int bidx   [B];

  for (genvar g = 0; g < B; g++) begin : g_empty
    assign fifo_empty[g] = (pushed[g] == popped[g]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < B; i++) bidx[i] <= 0;
    end else begin
      for (int i = 0; i < B; i++) begin
        if (fifo_req[i]) begin
          fifo_bits[i] <= wmem[i][popped[i] % 4][W-1-bidx[i]];
          if (bidx[i] == W-1) begin
            bidx[i]   <= 0;
            popped[i] <= popped[i] + 1;
          end else begin
            bidx[i] <= bidx[i] + 1;
          end
        end
      end
    end
  end

  logic [7:0] w1;
  int push1 = 0, pop1 = 0, bidx1 = 0;
  assign empty1[0] = (push1 == pop1);
  assign oflow1    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bidx1 <= 0;
    else if (req1[0]) begin
      bits1[0] <= w1[7-bidx1];
      if (bidx1 == 7) begin
        bidx1 <= 0;
        pop1  <= pop1 + 1;
      end else bidx1 <= bidx1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic push(input int b, input logic [W-1:0] d);
    wmem[b][pushed[b] % 4] = d;
    pushed[b]++;
  endtask

  task automatic wait_ptr(input int s);
    int t = 0;
    while (dut.ptr_q != IW'(s) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("sync_ptr", 64'(t < 400), 1);
  endtask

  // Predict service order: first pending block at or after the pointer, pointer
  // moves past each served block.
  task automatic collect(input int n, input int start, input bit stall10, input bit rnd);
    int           exp_b[$];
    logic [W-1:0] exp_d[$];
    int           rem[B];
    int           nxt[B];
    int           cur, j, got, cyc, stall, unstable;
    bit           have_prev;
    logic [W-1:0] prev_d;
    logic [IW-1:0] prev_b;
    for (int i = 0; i < B; i++) begin
      rem[i] = pushed[i] - popped[i];
      nxt[i] = popped[i];
    end
    cur = start;
    for (int k = 0; k < n; k++) begin
      j = cur;
      for (int s = 0; s < B; s++) begin
        j = (cur + s) % B;
        if (rem[j] > 0) break;
      end
      exp_b.push_back(j);
      exp_d.push_back(wmem[j][nxt[j] % 4]);
      nxt[j]++;
      rem[j]--;
      cur = (j + 1) % B;
    end
    got = 0; cyc = 0; stall = 0; unstable = 0; have_prev = 0;
    prev_d = '0; prev_b = '0;
    while (got < n && cyc < 2000 * n) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (|fifo_req) unstable++;
        if (have_prev && (out_data !== prev_d || out_block !== prev_b)) unstable++;
        have_prev = 1;
        prev_d = out_data;
        prev_b = out_block;
      end else have_prev = 0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall10 && got == 0 && out_valid && stall < 10) begin
        out_ready = 1'b0;
        stall++;
      end
      if (out_valid && out_ready) begin
        chk("word_block", 64'(out_block), 64'(exp_b[got]));
        chk("word_data", out_data, exp_d[got]);
        got++;
        have_prev = 0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("collect_count", 64'(got), 64'(n));
    chk("hold_stable", 64'(unstable), 0);
  endtask

  initial begin
    int t, lat, reqc, multi, wraps, prev_ptr, words1, reqc1, s, nb;
    logic [W-1:0] d;
    logic [7:0]   d1;
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; ready1 = 1'b1;
    oflow_clear = 1'b0; fifo_oflow = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_req", 64'(|fifo_req), 0);
    chk("rst_data", out_data, 0);
    chk("rst_block", 64'(out_block), 0);
    chk("rst_sticky", 64'(|oflow_sticky), 0);
    rst_n = 1'b1;

    // Idle sweep: nothing requested, pointer wraps twice in 400 cycles.
    enable = 1'b1;
    t = 0; wraps = 0; prev_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ((|fifo_req) || out_valid) t++;
      if (prev_ptr == B-1 && int'(dut.ptr_q) == 0) wraps++;
      prev_ptr = int'(dut.ptr_q);
    end
    chk("idle_quiet", 64'(t), 0);
    chk("idle_wraps", 64'(wraps), 2);

    // Single word from block 5: request length and latency.
    push(5, 64'hDEADBEEF_01234567);
    t = 0;
    while (!fifo_req[5] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("b5_req_seen", 64'(fifo_req[5]), 1);
    lat = 0; reqc = 0; multi = 0;
    while (!out_valid && lat < 200) begin
      if (fifo_req[5]) reqc++;
      if ($countones(fifo_req) > 1) multi++;
      @(negedge clk);
      lat++;
    end
    chk("b5_req_len", 64'(reqc), 64);
    chk("b5_onehot", 64'(multi), 0);
    chk("b5_latency", 64'(lat), 65);
    chk("b5_data", out_data, 64'hDEADBEEF_01234567);
    chk("b5_block", 64'(out_block), 5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b5_drop_valid", 64'(out_valid), 0);
    chk("b5_empty", 64'(fifo_empty[5]), 1);

    // Blocks 3 and 190 from pointer 4: 190 first, then 3 after the wrap.
    enable = 1'b0;
    push(3, {$urandom, $urandom});
    push(190, {$urandom, $urandom});
    wait_ptr(4);
    enable = 1'b1;
    collect(2, 4, 1'b1, 1'b0);

    // Single-block build: exactly one word despite the flag trailing the read.
    w1 = 8'($urandom);
    push1++;
    words1 = 0; reqc1 = 0; d1 = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (req1[0]) reqc1++;
      if (valid1 && ready1) begin
        words1++;
        d1 = data1;
      end
    end
    chk("b1_words", 64'(words1), 1);
    chk("b1_reqlen", 64'(reqc1), 8);
    chk("b1_data", 64'(d1), 64'(w1));
    chk("b1_block", 64'(blk1), 0);

    // Overflow: set beats a simultaneous clear; a lone clear wipes it.
    fifo_oflow[7] = 1'b1; oflow_clear = 1'b1;
    @(negedge clk);
    fifo_oflow = '0; oflow_clear = 1'b0;
    @(negedge clk);
    chk("of_set7", 64'(oflow_sticky[7]), 1);
    chk("of_count", 64'($countones(oflow_sticky)), 1);
    chk("of_any", 64'(oflow_any), 1);
    repeat (3) @(negedge clk);
    chk("of_hold", 64'(oflow_sticky[7]), 1);
    oflow_clear = 1'b1;
    @(negedge clk);
    oflow_clear = 1'b0;
    @(negedge clk);
    chk("of_clr", 64'(|oflow_sticky), 0);
    chk("of_any_clr", 64'(oflow_any), 0);
    s = int'($urandom_range(0, B-1));
    fifo_oflow[s] = 1'b1;
    @(negedge clk);
    fifo_oflow = '0;
    @(negedge clk);
    chk("of_rand", 64'(oflow_sticky[s]), 1);
    oflow_clear = 1'b1;
    @(negedge clk);
    oflow_clear = 1'b0;

    // Reset in the middle of a transfer.
    d = {$urandom, $urandom};
    push(5, d);
    t = 0;
    while (!fifo_req[5] && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    chk("mid_req_before", 64'(fifo_req[5]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_drop", 64'(|fifo_req), 0);
    chk("mid_ptr0", 64'(dut.ptr_q), 0);
    t = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) t++;
    end
    chk("mid_no_valid", 64'(t), 0);
    rst_n = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fifo_req[5] && t < 50);
    chk("mid_restart", 64'(t), 6);
    collect(1, 5, 1'b0, 1'b1);

    // Random traffic: random blocks, words and pointer start, random ready.
    for (int it = 0; it < 5; it++) begin
      enable = 1'b0;
      nb = int'($urandom_range(1, 4));
      for (int k = 0; k < nb; k++) push(int'($urandom_range(0, B-1)), {$urandom, $urandom});
      s = int'($urandom_range(0, B-1));
      wait_ptr(s);
      enable = 1'b1;
      collect(nb, s, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
